spi_reg_bridge: RTL and testbench

- Sits directly downstream of spi_slave and consumes its received bytes.
- Parses each SPI frame as a command byte followed by data bytes, and performs reads/writes on a small internal register file.
- Returns bytes to spi_slave to be shifted out on MISO.
- Register 0 bit 0 drives the board LED; the top level routes the LED through this block instead of through spi_slave.

---
 rtl/spi_reg_pkg.sv | 18 +
 rtl/spi_reg_if.sv | 13 +
 rtl/spi_reg_file.sv | 34 +++
 rtl/spi_reg_bridge.sv | 106 ++++++++++
 tb/tb_spi_reg_bridge.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register bridge: FSM states,
// command byte layout and the default response bytes.
package spi_reg_pkg;

  typedef enum logic [2:0] {
    WAIT_CMD = 3'd0,
    CMD      = 3'd1,
    WR       = 3'd2,
    RD       = 3'd3,
    IGNORE   = 3'd4
  } state_t;

  localparam int          CMD_RD_BIT    = 7;
  localparam logic [7:0]  SYNC_BYTE_DEF = 8'h5A;
  localparam logic [7:0]  ERR_BYTE      = 8'hFF;
  localparam logic [7:0]  ID_VALUE_DEF  = 8'hA5;

endpackage

// File: rtl/spi_reg_if.sv
// Byte-level link between spi_slave (master side) and the register bridge.
// rx_valid and tx_load are single-cycle strobes; there is no back-pressure,
// so a byte is transferred on every cycle its strobe is high.
interface spi_reg_if;
  logic       frame_active;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic [7:0] tx_data;
  logic       tx_load;

  modport master (output frame_active, rx_valid, rx_data, input tx_data, tx_load);
  modport slave  (input frame_active, rx_valid, rx_data, output tx_data, tx_load);
endinterface

// File: rtl/spi_reg_file.sv
// 2**ADDR_W x 8 register file: one write port, one combinational read port,
// top address hard-wired to a read-only ID constant.
module spi_reg_file #(
  parameter int         ADDR_W   = 4,
  parameter logic [7:0] ID_VALUE = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata,
  output logic              reg0_bit0
);

  localparam int               NREGS    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] TOP_ADDR = ADDR_W'(NREGS - 1);

  // The ID slot has no storage; only the writable registers are flops.
  logic [7:0] regs [NREGS-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS - 1; i++) regs[i] <= 8'h00;
    end else if (we && (waddr != TOP_ADDR)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata     = (raddr == TOP_ADDR) ? ID_VALUE : regs[raddr];
  assign reg0_bit0 = regs[0][0];

endmodule

// File: rtl/spi_reg_bridge.sv
// Parses SPI frames (command byte + data bytes) into register reads/writes
// and feeds response bytes back to spi_slave for MISO.
module spi_reg_bridge
  import spi_reg_pkg::*;
#(
  parameter int         ADDR_W    = 4,
  parameter logic [7:0] ID_VALUE  = ID_VALUE_DEF,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic      clk,
  input  logic      rst_n,
  spi_reg_if.slave  bus,
  output logic      led,
  output state_t    dbg_state
);

  state_t            state;
  logic              frame_q;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        tx_data_q;
  logic              tx_load_q;

  logic              frame_rise;
  logic              byte_ok;
  logic              cmd_reserved;
  logic              cmd_is_rd;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              we;

  assign frame_rise   = bus.frame_active && !frame_q;
  // A byte counts only inside a frame and never on the SYNC preload cycle.
  assign byte_ok      = bus.frame_active && !frame_rise && bus.rx_valid;
  assign cmd_reserved = |(bus.rx_data[6:0] >> ADDR_W);
  assign cmd_is_rd    = bus.rx_data[CMD_RD_BIT];
  assign cmd_addr     = bus.rx_data[ADDR_W-1:0];
  assign rd_addr      = (state == CMD) ? cmd_addr : addr;
  assign we           = byte_ok && (state == WR);

  spi_reg_file #(.ADDR_W(ADDR_W), .ID_VALUE(ID_VALUE)) u_regs (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (we),
    .waddr     (addr),
    .wdata     (bus.rx_data),
    .raddr     (rd_addr),
    .rdata     (rd_data),
    .reg0_bit0 (led)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= WAIT_CMD;
      frame_q   <= 1'b0;
      addr      <= '0;
      tx_data_q <= 8'h00;
      tx_load_q <= 1'b0;
    end else begin
      frame_q   <= bus.frame_active;
      tx_load_q <= 1'b0;
      if (!bus.frame_active) begin
        state <= WAIT_CMD;
        addr  <= '0;
      end else if (frame_rise) begin
        state     <= CMD;
        tx_data_q <= SYNC_BYTE;
        tx_load_q <= 1'b1;
      end else if (byte_ok) begin
        case (state)
          CMD: begin
            if (cmd_reserved) begin
              state     <= IGNORE;
              tx_data_q <= ERR_BYTE;
              tx_load_q <= 1'b1;
            end else if (cmd_is_rd) begin
              state     <= RD;
              tx_data_q <= rd_data;
              tx_load_q <= 1'b1;
              addr      <= cmd_addr + 1'b1;
            end else begin
              state <= WR;
              addr  <= cmd_addr;
            end
          end
          WR: addr <= addr + 1'b1;
          RD: begin
            tx_data_q <= rd_data;
            tx_load_q <= 1'b1;
            addr      <= addr + 1'b1;
          end
          IGNORE: begin
            tx_data_q <= ERR_BYTE;
            tx_load_q <= 1'b1;
          end
          default: state <= WAIT_CMD;
        endcase
      end
    end
  end

  assign bus.tx_data = tx_data_q;
  assign bus.tx_load = tx_load_q;
  assign dbg_state   = state;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Bench for spi_reg_bridge: frame-level reference model feeds an expected
// queue; a monitor pops and compares on every tx_load.
module tb_spi_reg_bridge;
  import spi_reg_pkg::*;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   led;
  state_t dbg_state;

  spi_reg_if bus ();

  spi_reg_bridge #(.ADDR_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .led       (led),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];

  // Reference model: register contents plus position within the current frame.
  logic [7:0] mem [16];
  int         m_idx;
  logic [7:0] m_cmd;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_rd(input int a);
    return (a == 15) ? 8'hA5 : mem[a];
  endfunction

  task automatic model_byte(input logic [7:0] b, output logic resp);
    logic [7:0] c;
    int a;
    resp = 1'b0;
    c = (m_idx == 0) ? b : m_cmd;
    if (m_idx == 0) m_cmd = b;
    if (c[6:4] != 3'd0) begin
      exp_q.push_back(8'hFF);
      resp = 1'b1;
    end else if (c[7]) begin
      a = (int'(c[3:0]) + m_idx) % 16;
      exp_q.push_back(m_rd(a));
      resp = 1'b1;
    end else if (m_idx > 0) begin
      a = (int'(c[3:0]) + m_idx - 1) % 16;
      if (a != 15) mem[a] = b;
    end
    m_idx++;
  endtask

  // Monitor
  logic prev_load = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_load = 1'b0;
    end else begin
      if (bus.tx_load) begin
        chk("no_back_to_back_load", {7'd0, prev_load}, 8'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_load: got %h expected no load", bus.tx_data);
        end else begin
          chk("tx_data", bus.tx_data, exp_q.pop_front());
        end
      end
      prev_load = bus.tx_load;
    end
  end

  task automatic frame_start(input bit coincide);
    @(posedge clk); #1;
    bus.frame_active = 1'b1;
    bus.rx_valid     = coincide;
    bus.rx_data      = 8'h01;
    m_idx = 0;
    exp_q.push_back(8'h5A);
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    @(negedge clk);
    chk("sync_load", {7'd0, bus.tx_load}, 8'd1);
    repeat (8) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic resp;
    @(posedge clk); #1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    model_byte(b, resp);
    @(negedge clk);
    chk("load_latency", {7'd0, bus.tx_load}, {7'd0, resp});
    chk("led", {7'd0, led}, {7'd0, mem[0][0]});
    repeat (8) @(posedge clk);
  endtask

  task automatic frame_end(input bit coincide);
    @(posedge clk); #1;
    bus.frame_active = 1'b0;
    bus.rx_valid     = coincide;
    bus.rx_data      = 8'h00;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    @(negedge clk);
    chk("end_no_load", {7'd0, bus.tx_load}, 8'd0);
    chk("end_state", 8'(dbg_state), 8'(WAIT_CMD));
    repeat (3) @(posedge clk);
  endtask

  task automatic read_all();
    frame_start(1'b0);
    send_byte(8'h80);
    for (int i = 0; i < 15; i++) send_byte(8'($urandom));
    frame_end(1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    m_idx = 0;
    m_cmd = 8'h00;
    bus.frame_active = 1'b0;
    bus.rx_valid     = 1'b0;
    bus.rx_data      = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx_data", bus.tx_data, 8'h00);
    chk("reset_tx_load", {7'd0, bus.tx_load}, 8'd0);
    chk("reset_led", {7'd0, led}, 8'd0);
    chk("reset_state", 8'(dbg_state), 8'(WAIT_CMD));
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // LED on then off via reg 0
    frame_start(1'b0); send_byte(8'h00); send_byte(8'h01); frame_end(1'b0);
    frame_start(1'b0); send_byte(8'h00); send_byte(8'h02); frame_end(1'b0);

    // Burst write across the ID register and wrap, then read back
    frame_start(1'b0);
    send_byte(8'h0E); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    frame_end(1'b0);
    frame_start(1'b0);
    send_byte(8'h8E); send_byte(8'h00); send_byte(8'h00);
    frame_end(1'b0);

    // Reserved command bits
    frame_start(1'b0); send_byte(8'h30); send_byte(8'h44); send_byte(8'h55); frame_end(1'b0);

    // Frame dropped after command; next frame writes reg 0
    frame_start(1'b0); send_byte(8'h03); frame_end(1'b0);
    frame_start(1'b0); send_byte(8'h00); send_byte(8'h07); frame_end(1'b0);

    // rx_valid coincident with frame rise and with frame fall
    frame_start(1'b1); send_byte(8'h01); send_byte(8'h9C); frame_end(1'b1);

    // Randomized frames
    for (int f = 0; f < 30; f++) begin
      logic [7:0] cmd;
      int n;
      cmd = {1'($urandom), 3'b000, 4'($urandom)};
      if ($urandom_range(0, 5) == 0) cmd[6:4] = 3'($urandom_range(1, 7));
      n = $urandom_range(0, 5);
      frame_start($urandom_range(0, 4) == 0);
      send_byte(cmd);
      for (int k = 0; k < n; k++) send_byte(8'($urandom));
      frame_end($urandom_range(0, 3) == 0);
    end
    read_all();

    // Reset mid write burst
    frame_start(1'b0); send_byte(8'h00); send_byte(8'h55); send_byte(8'h66);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("midreset_led", {7'd0, led}, 8'd0);
    chk("midreset_state", 8'(dbg_state), 8'(WAIT_CMD));
    chk("midreset_tx_data", bus.tx_data, 8'h00);
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    exp_q.delete();
    bus.frame_active = 1'b0;
    #20;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    read_all();

    repeat (5) @(posedge clk);
    chk("exp_q_drained", 8'(exp_q.size()), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
